// File: rtl/logic_seq_pkg.sv
// ---------------------------------------------------------------------------
// logic_seq_pkg
// Shared types for the logic operation sequencer.
//   op_t    : 3-bit operation index shown on oOP and the seven-segment digit
//   state_t : stepping mode of the sequencer FSM (manual key / timed auto)
//   evalOp  : one-bit evaluation of an operation on two operand bits
// ---------------------------------------------------------------------------
package logic_seq_pkg;

    typedef enum logic [2:0] {
        OP_PASS_A = 3'd0,
        OP_NOT_A  = 3'd1,
        OP_AND    = 3'd2,
        OP_OR     = 3'd3,
        OP_XOR    = 3'd4,
        OP_NAND   = 3'd5,
        OP_NOR    = 3'd6,
        OP_XNOR   = 3'd7
    } op_t;

    typedef enum logic {
        S_MANUAL = 1'b0,
        S_AUTO   = 1'b1
    } state_t;

    function automatic logic evalOp(input op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_PASS_A: r = a;
            OP_NOT_A:  r = ~a;
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_XOR:    r = a ^ b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XNOR:   r = ~(a ^ b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Debounces an already-synchronized active-low pushbutton and produces a
// one-cycle pulse on each accepted press (debounced 1->0). Release gives no
// pulse.
// Ports:
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset
//   keyN_i   : synchronized key level, 0 = pressed
//   level_o  : debounced key level, 1 = released (reset value)
//   press_o  : one-cycle pulse when the debounced level falls
// ---------------------------------------------------------------------------
module key_debounce
    import logic_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic keyN_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW      = $clog2(DEBOUNCE_CYC + 1);
    // Two extra cycles cover the synchronizer flops, which reset to the
    // released level and would otherwise fake a release after reset.
    localparam int ARM_CYC = DEBOUNCE_CYC + 2;
    localparam int AW      = $clog2(ARM_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [AW-1:0] ARM_LAST = AW'(ARM_CYC - 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] armCnt_q, armCnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q  <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            armed_q  <= 1'b0;
            armCnt_q <= '0;
        end else begin
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
            armed_q  <= armed_d;
            armCnt_q <= armCnt_d;
        end
    end

    // The level only follows the input after DEBOUNCE_CYC consecutive
    // differing samples; any agreeing sample restarts the count. Presses are
    // ignored until the key has been seen released after reset, so a key
    // held through reset never produces a press.
    always_comb begin
        level_d  = level_q;
        cnt_d    = '0;
        armed_d  = armed_q;
        armCnt_d = armCnt_q;

        if (keyN_i != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = keyN_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if (!armed_q) begin
            if (keyN_i) begin
                if (armCnt_q == ARM_LAST) begin
                    armed_d = 1'b1;
                end else begin
                    armCnt_d = armCnt_q + AW'(1);
                end
            end else begin
                armCnt_d = '0;
            end
        end

        press_d = armed_q & level_q & ~level_d;
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/logic_op_sequencer.sv
// ---------------------------------------------------------------------------
// logic_op_sequencer
// Steps through eight one-bit logic operations, either on a debounced key
// press (manual) or on a fixed-period tick (auto), and shows the registered
// result of the current operation on the operand switches.
// Ports:
//   iCLK_50  : system clock (only clock)
//   iRST     : asynchronous active-high reset
//   iSTEP_N  : raw active-low step pushbutton
//   iAUTO    : raw switch, 1 requests auto stepping
//   iCLR     : raw switch, 1 holds the op index at 0
//   iA, iB   : raw operand switches
//   oOP      : current operation index
//   oRESULT  : registered result of oOP applied to the operands
//   oSTEP    : one-cycle pulse on every op advance
//   oAUTO    : 1 while in auto mode
//   oHEX_D   : active-low seven-segment digit of oOP (bit 6 = g .. bit 0 = a)
// ---------------------------------------------------------------------------
module logic_op_sequencer
    import logic_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int STEP_DIV     = 50000000
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic       iSTEP_N,
    input  logic       iAUTO,
    input  logic       iCLR,
    input  logic       iA,
    input  logic       iB,
    output logic [2:0] oOP,
    output logic       oRESULT,
    output logic       oSTEP,
    output logic       oAUTO,
    output logic [6:0] oHEX_D
);

    localparam int PW = $clog2(STEP_DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

    // Synchronizer bit positions; the key idles high so its flops reset to 1.
    localparam int SYN_KEY  = 0;
    localparam int SYN_AUTO = 1;
    localparam int SYN_CLR  = 2;
    localparam int SYN_A    = 3;
    localparam int SYN_B    = 4;
    localparam logic [4:0] SYNC_RST = 5'b00001;

    logic [4:0]    rawIn;
    logic [4:0]    sync1_q, sync2_q;
    logic          keyLevel, keyPress, keyReq;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    op_t           op_q, op_d;
    logic          step_q, step_d;
    logic          result_q, result_d;
    logic          tickReq;
    logic          advance;
    logic [6:0]    hexSeg;

    assign rawIn = {iB, iA, iCLR, iAUTO, iSTEP_N};

    // Two-flop synchronizers for every asynchronous switch and the key.
    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= rawIn;
            sync2_q <= sync1_q;
        end
    end

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_keyDebounce (
        .clk_i   (iCLK_50),
        .rst_i   (iRST),
        .keyN_i  (sync2_q[SYN_KEY]),
        .level_o (keyLevel),
        .press_o (keyPress)
    );

    // A press is only honoured while the debounced level agrees the key is down.
    assign keyReq = keyPress & ~keyLevel;

    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            state_q  <= S_MANUAL;
            presc_q  <= '0;
            op_q     <= OP_PASS_A;
            step_q   <= 1'b0;
            result_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            op_q     <= op_d;
            step_q   <= step_d;
            result_q <= result_d;
        end
    end

    // Mode FSM, prescaler and op advance. The prescaler sits at 0 in manual
    // mode, so auto mode always starts a full period after entry. A key press
    // landing on the tick cycle merges into a single advance; the prescaler
    // wraps to 0 on that same cycle, keeping the next tick a full period away.
    // Clear wins over any advance and swallows its step pulse.
    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        tickReq  = 1'b0;
        op_d     = op_q;
        step_d   = 1'b0;

        case (state_q)
            S_MANUAL: if (sync2_q[SYN_AUTO])  state_d = S_AUTO;
            S_AUTO:   if (!sync2_q[SYN_AUTO]) state_d = S_MANUAL;
            default:  state_d = S_MANUAL;
        endcase

        if (state_q == S_AUTO) begin
            if (presc_q == PRESC_LAST) begin
                tickReq = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        advance = keyReq | tickReq;

        if (sync2_q[SYN_CLR]) begin
            op_d = OP_PASS_A;
        end else if (advance) begin
            op_d   = op_t'(op_q + 3'd1);
            step_d = 1'b1;
        end

        result_d = evalOp(op_q, sync2_q[SYN_A], sync2_q[SYN_B]);
    end

    // Active-low segments, bit order g f e d c b a.
    always_comb begin
        case (op_q)
            3'd0:    hexSeg = 7'b1000000;
            3'd1:    hexSeg = 7'b1111001;
            3'd2:    hexSeg = 7'b0100100;
            3'd3:    hexSeg = 7'b0110000;
            3'd4:    hexSeg = 7'b0011001;
            3'd5:    hexSeg = 7'b0010010;
            3'd6:    hexSeg = 7'b0000010;
            3'd7:    hexSeg = 7'b1111000;
            default: hexSeg = 7'b1111111;
        endcase
    end

    assign oOP     = op_q;
    assign oRESULT = result_q;
    assign oSTEP   = step_q;
    assign oAUTO   = (state_q == S_AUTO);
    assign oHEX_D  = hexSeg;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_logic_op_sequencer
// Directed bench for logic_op_sequencer with short debounce and step period.
// ---------------------------------------------------------------------------
module tb_logic_op_sequencer;

    localparam int DEB = 4;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stepN = 1'b1;
    logic       autoIn = 1'b0;
    logic       clr = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [2:0] op;
    logic       result;
    logic       step;
    logic       autoOut;
    logic [6:0] hex;

    int testsRun = 0;
    int testsFailed = 0;

    // Running totals kept by the monitor; tests snapshot them.
    int stepCount = 0;
    int wrapCount = 0;
    int cycleCnt = 0;
    int lastStepCycle = -1;
    int lastGap = 0;
    logic [2:0] prevOp = 3'd0;

    int stepBase;
    int wrapBase;

    // Expected results per op, bit index = {a,b}.
    logic [3:0] ttMask [8];
    logic [6:0] hexTab [8];

    always #5 clk = ~clk;

    logic_op_sequencer #(
        .DEBOUNCE_CYC(DEB),
        .STEP_DIV(DIV)
    ) dut (
        .iCLK_50 (clk),
        .iRST    (rst),
        .iSTEP_N (stepN),
        .iAUTO   (autoIn),
        .iCLR    (clr),
        .iA      (a),
        .iB      (b),
        .oOP     (op),
        .oRESULT (result),
        .oSTEP   (step),
        .oAUTO   (autoOut),
        .oHEX_D  (hex)
    );

    // Step pulses, their spacing and 7->0 wraps, observed on the falling edge.
    always @(negedge clk) begin
        cycleCnt = cycleCnt + 1;
        if (step) begin
            stepCount = stepCount + 1;
            if (lastStepCycle >= 0) lastGap = cycleCnt - lastStepCycle;
            lastStepCycle = cycleCnt;
        end
        if (prevOp == 3'd7 && op == 3'd0) wrapCount = wrapCount + 1;
        prevOp = op;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun = testsRun + 1;
        if (got !== exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic kN, input logic au, input logic cl,
                                 input logic av, input logic bv);
        stepN  = kN;
        autoIn = au;
        clr    = cl;
        a      = av;
        b      = bv;
    endtask

    task automatic pressKey();
        stepN = 1'b0;
        waitCycles(10);
        stepN = 1'b1;
        waitCycles(12);
    endtask

    task automatic glitch();
        stepN = 1'b0;
        waitCycles(3);
        stepN = 1'b1;
        waitCycles(3);
    endtask

    initial begin
        ttMask[0] = 4'b1100; ttMask[1] = 4'b0011; ttMask[2] = 4'b1000; ttMask[3] = 4'b1110;
        ttMask[4] = 4'b0110; ttMask[5] = 4'b0111; ttMask[6] = 4'b0001; ttMask[7] = 4'b1001;
        hexTab[0] = 7'h40; hexTab[1] = 7'h79; hexTab[2] = 7'h24; hexTab[3] = 7'h30;
        hexTab[4] = 7'h19; hexTab[5] = 7'h12; hexTab[6] = 7'h02; hexTab[7] = 7'h78;

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitCycles(3);
        checkOutput("rst op", op, 0);
        checkOutput("rst result", result, 0);
        checkOutput("rst step", step, 0);
        checkOutput("rst auto", autoOut, 0);
        checkOutput("rst hex", hex, 7'h40);
        rst = 1'b0;
        waitCycles(20);

        // Manual step: 2 sync + 4 debounce + 1 update cycles to the pulse
        stepBase = stepCount;
        stepN = 1'b0;
        waitCycles(7);
        checkOutput("manual step pulse", step, 1);
        checkOutput("manual op", op, 1);
        waitCycles(1);
        checkOutput("manual pulse width", step, 0);
        waitCycles(2);
        stepN = 1'b1;
        waitCycles(12);
        checkOutput("manual step count", stepCount - stepBase, 1);
        checkOutput("manual op held", op, 1);

        // Bounce: glitches alone, then glitches followed by a real press
        stepBase = stepCount;
        glitch(); glitch(); glitch();
        waitCycles(10);
        checkOutput("glitch step count", stepCount - stepBase, 0);
        checkOutput("glitch op", op, 1);
        glitch(); glitch();
        pressKey();
        checkOutput("bounce step count", stepCount - stepBase, 1);
        checkOutput("bounce op", op, 2);

        // Truth table and digit sweep over all ops
        clr = 1'b1;
        waitCycles(3);
        checkOutput("clr op", op, 0);
        clr = 1'b0;
        waitCycles(3);
        for (int o = 0; o < 8; o++) begin
            checkOutput($sformatf("sweep op%0d", o), op, o);
            checkOutput($sformatf("hex op%0d", o), hex, hexTab[o]);
            for (int ab = 0; ab < 4; ab++) begin
                a = ab[1];
                b = ab[0];
                waitCycles(3);
                checkOutput($sformatf("result op%0d ab%0d", o, ab), result, ttMask[o][ab]);
            end
            pressKey();
        end
        checkOutput("manual wrap op", op, 0);

        // Auto mode: first tick 10 cycles after entry, then every 10
        stepBase = stepCount;
        wrapBase = wrapCount;
        autoIn = 1'b1;
        waitCycles(3);
        checkOutput("auto flag", autoOut, 1);
        waitCycles(10);
        checkOutput("auto first step", step, 1);
        checkOutput("auto first op", op, 1);
        waitCycles(72);
        autoIn = 1'b0;
        waitCycles(6);
        checkOutput("auto flag off", autoOut, 0);
        checkOutput("auto step count", stepCount - stepBase, 8);
        checkOutput("auto wrap count", wrapCount - wrapBase, 1);
        checkOutput("auto end op", op, 0);
        checkOutput("auto step gap", lastGap, DIV);

        // Collision: key press lands on the first tick
        stepBase = stepCount;
        autoIn = 1'b1;
        waitCycles(6);
        stepN = 1'b0;
        waitCycles(7);
        checkOutput("collide step", step, 1);
        checkOutput("collide op", op, 1);
        waitCycles(1);
        stepN = 1'b1;
        waitCycles(8);
        checkOutput("collide quiet", step, 0);
        checkOutput("collide op held", op, 1);
        waitCycles(1);
        checkOutput("collide next tick", step, 1);
        checkOutput("collide next op", op, 2);
        waitCycles(1);
        checkOutput("collide gap", lastGap, DIV);
        checkOutput("collide step count", stepCount - stepBase, 2);
        autoIn = 1'b0;
        waitCycles(6);

        // Reset mid-step at op 5 in auto mode, key held through reset
        clr = 1'b1;
        waitCycles(3);
        clr = 1'b0;
        a = 1'b1;
        b = 1'b0;
        waitCycles(3);
        autoIn = 1'b1;
        waitCycles(53);
        checkOutput("pre-rst op", op, 5);
        checkOutput("pre-rst step", step, 1);
        checkOutput("pre-rst auto", autoOut, 1);
        checkOutput("pre-rst result", result, 1);
        rst = 1'b1;
        autoIn = 1'b0;
        stepN = 1'b0;
        #1;
        checkOutput("async rst op", op, 0);
        checkOutput("async rst step", step, 0);
        checkOutput("async rst auto", autoOut, 0);
        checkOutput("async rst result", result, 0);
        checkOutput("async rst hex", hex, 7'h40);
        stepBase = stepCount;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(30);
        checkOutput("held key steps", stepCount - stepBase, 0);
        checkOutput("held key op", op, 0);
        stepN = 1'b1;
        waitCycles(20);

        // Clear overrides a press
        pressKey();
        checkOutput("pre-clr op", op, 1);
        clr = 1'b1;
        waitCycles(3);
        checkOutput("clr forces op", op, 0);
        stepBase = stepCount;
        pressKey();
        checkOutput("clr press steps", stepCount - stepBase, 0);
        checkOutput("clr press op", op, 0);
        clr = 1'b0;
        waitCycles(3);
        checkOutput("clr release op", op, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
